// File: rtl/mul16_seq.sv
// Sequential 16x16 multiplier returning the low 16 bits of the product.
// A single add16 instance is reused once per multiplier bit in a shift-and-add loop.

module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum
);
  assign sum = x + y;
endmodule

// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one shift-and-add step per cycle, busy=1
// DONE  | product just loaded, done=1, ready=1 (back-to-back start allowed)
module mul16_seq #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        last_step;

  assign addend = mplier[0] ? mcand : 16'h0000;

  add16 u_add16 (
    .x   (acc),
    .y   (addend),
    .sum (sum)
  );

  // Early exit fires once no set multiplier bits remain above the one in use now.
  assign last_step = (cnt == 4'd15) || (EARLY_EXIT && (mplier[15:1] == 15'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= 16'h0000;
      mplier  <= 16'h0000;
      acc     <= 16'h0000;
      cnt     <= 4'd0;
      product <= 16'h0000;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= 16'h0000;
            cnt    <= 4'd0;
            state  <= S_RUN;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end else begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
          end
          done <= 1'b0;
        end
        S_RUN: begin
          acc    <= sum;
          mcand  <= {mcand[14:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
          cnt    <= cnt + 4'd1;
          if (last_step) begin
            product <= sum;
            state   <= S_DONE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: one instance without and one with early exit,
// checked against a plain-arithmetic reference model.

module tb_mul16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        ready0, busy0, done0, ready1, busy1, done1;
  logic [15:0] product0, product1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int exp_p0[$], exp_l0[$], exp_s0[$];
  int exp_p1[$], exp_l1[$], exp_s1[$];

  mul16_seq #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .ready(ready0), .busy(busy0), .done(done0), .product(product0)
  );

  mul16_seq #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .product(product1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ref_prod(input logic [15:0] x, input logic [15:0] y);
    int unsigned full;
    full = int'(x) * int'(y);
    return int'(full % 65536);
  endfunction

  // Cycles from start edge to done: k+1 where k counts up to the top set bit of b.
  function automatic int ref_lat(input bit early, input logic [15:0] y);
    int k;
    if (!early) return 17;
    k = 1;
    for (int i = 0; i < 16; i++) if (y[i]) k = i + 1;
    return k + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (exp_p0.size() == 0) chk("spurious_done0", 1, 0);
      else begin
        chk("product0", int'(product0), exp_p0.pop_front());
        chk("latency0", cyc - exp_s0.pop_front() + 1, exp_l0.pop_front());
      end
    end
    if (rst_n && done1) begin
      if (exp_p1.size() == 0) chk("spurious_done1", 1, 0);
      else begin
        chk("product1", int'(product1), exp_p1.pop_front());
        chk("latency1", cyc - exp_s1.pop_front() + 1, exp_l1.pop_front());
      end
    end
  end

  task automatic issue(input bit inst, input logic [15:0] av, input logic [15:0] bv);
    int n = 0;
    while (!(inst ? ready1 : ready0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    if (inst) begin start1 = 1'b1; a1 = av; b1 = bv; end
    else      begin start0 = 1'b1; a0 = av; b0 = bv; end
    @(posedge clk); #1;
    if (inst) begin
      exp_p1.push_back(ref_prod(av, bv)); exp_l1.push_back(ref_lat(1'b1, bv)); exp_s1.push_back(cyc);
      start1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom);
    end else begin
      exp_p0.push_back(ref_prod(av, bv)); exp_l0.push_back(ref_lat(1'b0, bv)); exp_s0.push_back(cyc);
      start0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
    end
  endtask

  task automatic drain(input bit inst);
    int n = 0;
    while (((inst ? exp_p1.size() : exp_p0.size()) != 0 || !(inst ? ready1 : ready0)) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) chk(inst ? "drain_timeout1" : "drain_timeout0", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done0();
    int n = 0;
    @(negedge clk);
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("done_timeout0", 0, 1);
  endtask

  initial begin
    int nb;
    logic [15:0] ra, rb;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [15:0] ra, rb;
    #12;
    chk("rst_ready0", int'(ready0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_product0", int'(product0), 0);
    chk("rst_ready1", int'(ready1), 1);
    @(negedge clk); rst_n = 1'b1;

    // Basic multiply with busy-length check.
    issue(1'b0, 16'd3, 16'd5);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy0) nb++;
    end
    chk("busy_cycles", nb, 16);
    chk("ready_after", int'(ready0), 1);
    drain(1'b0);

    issue(1'b0, 16'hFFFF, 16'hFFFF); drain(1'b0);
    issue(1'b0, 16'hFFFD, 16'h0007); drain(1'b0);
    issue(1'b0, 16'h0100, 16'h0100); drain(1'b0);

    // Start pulse during RUN must be ignored.
    issue(1'b0, 16'd2, 16'd9);
    repeat (3) @(posedge clk);
    #1 start0 = 1'b1; a0 = 16'd7; b0 = 16'd7;
    @(posedge clk); #1 start0 = 1'b0;
    drain(1'b0);
    repeat (20) @(negedge clk);
    chk("no_second_op", int'(busy0), 0);

    // Back-to-back start issued in the DONE cycle; old product must hold.
    issue(1'b0, 16'd3, 16'd6);
    wait_done0();
    issue(1'b0, 16'd4, 16'd4);
    chk("b2b_busy", int'(busy0), 1);
    repeat (8) @(negedge clk);
    chk("b2b_hold", int'(product0), 16'h0012);
    drain(1'b0);

    // Reset during RUN aborts cleanly.
    issue(1'b0, 16'h1111, 16'h2222);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_ready", int'(ready0), 1);
    chk("abort_product", int'(product0), 0);
    exp_p0.delete(); exp_l0.delete(); exp_s0.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", int'(product0), 0);
    issue(1'b0, 16'd6, 16'd6); drain(1'b0);

    // Early-exit instance.
    issue(1'b1, 16'h1234, 16'h0001); drain(1'b1);
    issue(1'b1, 16'hABCD, 16'h0000); drain(1'b1);
    issue(1'b1, 16'h0003, 16'h8000); drain(1'b1);

    // Random traffic, sometimes back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(1'b0, ra, rb);
      rb = 16'($urandom) & 16'((32'd1 << $urandom_range(0, 16)) - 1);
      issue(1'b1, ra, rb);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
    end
    drain(1'b0);
    drain(1'b1);
    chk("queue0_empty", exp_p0.size(), 0);
    chk("queue1_empty", exp_p1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
